// File: rtl/l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter
//
// Two-requester front end for the shared L2 cache. Port 0 is the L1
// instruction side, port 1 the L1 data side. One request is granted at a
// time. Its address, write block and operation are latched. The L2 strobes
// are held for the whole L2 transaction, and the L2 response is routed back
// to the granted port only.
//
// Handshake (request side): a port requests by raising pX_read and/or
// pX_write and holding it until pX_ready pulses for one cycle. A port with
// both read and write high is served as a write. A request dropped before it
// is granted is forgotten. Once granted, the port's inputs are not looked at
// again until the transaction ends. On the L2 side, l2_read/l2_write stay
// high until the single-cycle l2_ready pulse. They drop in that same cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   p0_addr / p1_addr        request block address
//   p0_data_in / p1_data_in  write block (BLOCK_SIZE x DATA_WIDTH packed)
//   p0_read / p1_read        read request
//   p0_write / p1_write      write request
//   p0_ready / p1_ready      one-cycle completion pulse to the granted port
//   rsp_data                 returned block (meaningful while a ready is high)
//   rsp_valid, rsp_hit       returned block valid / L2 reported a hit
//   l2_addr, l2_data_out     latched address / write block toward the L2
//   l2_read, l2_write        L2 strobes
//   l2_data_in               block from the L2
//   l2_block_valid, l2_hit   L2 response qualifiers, sampled with l2_ready
//   l2_ready                 one-cycle L2 completion pulse
//   timeout_err              sticky flag, set when the L2 never answered
//   dbg_state                current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module l2_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int BLOCK_SIZE     = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            p0_addr,
  input  logic [ADDR_WIDTH-1:0]            p1_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_data_in,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_data_in,
  input  logic                             p0_read,
  input  logic                             p1_read,
  input  logic                             p0_write,
  input  logic                             p1_write,
  output logic                             p0_ready,
  output logic                             p1_ready,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] rsp_data,
  output logic                             rsp_valid,
  output logic                             rsp_hit,
  output logic [ADDR_WIDTH-1:0]            l2_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
  output logic                             l2_read,
  output logic                             l2_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
  input  logic                             l2_block_valid,
  input  logic                             l2_hit,
  input  logic                             l2_ready,
  output logic                             timeout_err,
  output logic [1:0]                       dbg_state
);

  localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_port;        // port owning the current transaction
  logic               r_last_grant;  // port granted most recently
  logic               r_op_write;    // 1 = write, 0 = read
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BLK_W-1:0]   r_wdata;
  logic [BLK_W-1:0]   r_rsp_data;
  logic               r_rsp_valid;
  logic               r_rsp_hit;
  logic               r_timeout_err;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_req0;
  logic               w_req1;
  logic               w_grant_port;
  logic               w_grant_write;
  logic               w_grant_en;
  logic               w_capture;
  logic               w_expire;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_timeout;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_req0 = p0_read | p0_write;
  assign w_req1 = p1_read | p1_write;

  // On contention, round-robin favours the port that was not granted last.
  // last_grant resets to 1 so port 0 wins the very first contention.
  always_comb begin
    w_grant_port = 1'b0;
    if (w_req0 && w_req1) begin
      if (FIXED_PRIORITY != 0) begin
        w_grant_port = 1'b0;
      end else begin
        w_grant_port = ~r_last_grant;
      end
    end else if (w_req1) begin
      w_grant_port = 1'b1;
    end
  end

  // Read and write together on one port are served as a write.
  assign w_grant_write = w_grant_port ? p1_write : p0_write;

  // ---------------------------------------------------------------------------
  // Timeout
  // ---------------------------------------------------------------------------
  // The counter holds the number of BUSY cycles already spent. The cycle in
  // which the incremented value hits the limit is the last BUSY cycle.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == TO_LIMIT);

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    w_capture    = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 || w_req1) begin
          w_grant_en   = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A response that arrives in the same cycle as the timeout still counts.
        if (l2_ready) begin
          w_capture    = 1'b1;
          w_state_next = ST_DONE;
        end else if (w_timeout) begin
          w_expire     = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant, request latch and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port        <= 1'b0;
      r_last_grant  <= 1'b1;
      r_op_write    <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rsp_data    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
    end else begin
      if (w_grant_en) begin
        r_port       <= w_grant_port;
        r_last_grant <= w_grant_port;
        r_op_write   <= w_grant_write;
        r_addr       <= w_grant_port ? p1_addr : p0_addr;
        r_wdata      <= w_grant_port ? p1_data_in : p0_data_in;
      end

      if (r_state == ST_BUSY) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= '0;
      end

      if (w_capture) begin
        r_rsp_data  <= l2_data_in;
        r_rsp_valid <= l2_block_valid;
        r_rsp_hit   <= l2_hit;
      end else if (w_expire) begin
        r_timeout_err <= 1'b1;
        r_rsp_valid   <= 1'b0;
        r_rsp_hit     <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Strobes drop combinationally on l2_ready so the L2 never sees a stale
  // request in its completion cycle.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (r_state == ST_BUSY) begin
      l2_read  = ~r_op_write & ~l2_ready;
      l2_write =  r_op_write & ~l2_ready;
    end
    if (r_state == ST_DONE) begin
      p0_ready = ~r_port;
      p1_ready =  r_port;
    end
  end

  assign l2_addr     = r_addr;
  assign l2_data_out = r_wdata;
  assign rsp_data    = r_rsp_data;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_hit     = r_rsp_hit;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_port_arbiter
//
// Two arbiters share one stimulus: instance 0 is round-robin, instance 1 is
// fixed priority. Both use an 8-cycle timeout. A small L2 responder per
// instance answers l2_ready a programmable number of strobe cycles after a
// request, or never. A transaction-level model predicts every output each
// cycle. A ready-pulse scoreboard holds the expected order of served ports.
// -----------------------------------------------------------------------------
module tb_l2_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BS = 32;
  localparam int BW = DW * BS;
  localparam int TO = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [AW-1:0] p0_addr, p1_addr;
  logic [BW-1:0] p0_data_in, p1_data_in;
  logic          p0_read, p1_read, p0_write, p1_write;

  logic          p0_ready [2];
  logic          p1_ready [2];
  logic [BW-1:0] rsp_data [2];
  logic          rsp_valid [2];
  logic          rsp_hit [2];
  logic [AW-1:0] l2_addr [2];
  logic [BW-1:0] l2_data_out [2];
  logic          l2_read [2];
  logic          l2_write [2];
  logic [BW-1:0] l2_data_in [2];
  logic          l2_block_valid [2];
  logic          l2_hit [2];
  logic          l2_ready [2];
  logic          timeout_err [2];
  logic [1:0]    dbg_state [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    l2_port_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS),
      .FIXED_PRIORITY(g), .TIMEOUT_CYCLES(TO)
    ) u_dut (
      .clk(clk), .rst(rst),
      .p0_addr(p0_addr), .p1_addr(p1_addr),
      .p0_data_in(p0_data_in), .p1_data_in(p1_data_in),
      .p0_read(p0_read), .p1_read(p1_read),
      .p0_write(p0_write), .p1_write(p1_write),
      .p0_ready(p0_ready[g]), .p1_ready(p1_ready[g]),
      .rsp_data(rsp_data[g]), .rsp_valid(rsp_valid[g]), .rsp_hit(rsp_hit[g]),
      .l2_addr(l2_addr[g]), .l2_data_out(l2_data_out[g]),
      .l2_read(l2_read[g]), .l2_write(l2_write[g]),
      .l2_data_in(l2_data_in[g]), .l2_block_valid(l2_block_valid[g]),
      .l2_hit(l2_hit[g]), .l2_ready(l2_ready[g]),
      .timeout_err(timeout_err[g]), .dbg_state(dbg_state[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got low64 %0h, want low64 %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [BW-1:0] make_blk(input logic [31:0] seed);
    logic [BW-1:0] b;
    for (int w = 0; w < BS; w++) b[w*DW +: DW] = seed + 32'(w);
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // L2 responder: counts strobe cycles and pulses l2_ready on the l2_lat-th
  // ---------------------------------------------------------------------------
  int          l2_lat  = 3;
  logic        l2_hang = 1'b0;
  logic        hit_v   = 1'b1;
  logic        valid_v = 1'b1;
  logic [31:0] l2_pat  = 32'hDEAD_BEEF;
  int          l2_cnt [2];

  initial begin
    logic pulsed;
    for (int i = 0; i < 2; i++) begin
      l2_ready[i] = 1'b0; l2_hit[i] = 1'b0; l2_block_valid[i] = 1'b0;
      l2_data_in[i] = '0; l2_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      pulsed = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (rst || l2_ready[i]) begin
          l2_ready[i] = 1'b0;
          l2_cnt[i]   = 0;
        end else if (l2_read[i] || l2_write[i]) begin
          l2_cnt[i]++;
          if (!l2_hang && l2_cnt[i] == l2_lat) begin
            l2_ready[i]       = 1'b1;
            l2_data_in[i]     = make_blk(l2_pat);
            l2_hit[i]         = hit_v;
            l2_block_valid[i] = valid_v;
            pulsed            = 1'b1;
          end
        end else begin
          l2_cnt[i] = 0;
        end
      end
      if (pulsed) l2_pat = l2_pat + 32'h0000_1111;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  logic          m_live = 1'b0;
  logic          m_busy [2];   // a transaction is in flight at the L2
  logic          m_due [2];    // a ready pulse is owed this cycle
  logic          m_owner [2];
  logic          m_wr [2];
  logic          m_last [2];
  logic [AW-1:0] m_addr [2];
  logic [BW-1:0] m_wdata [2];
  logic [BW-1:0] m_rdata [2];
  logic          m_rv [2];
  logic          m_rh [2];
  logic          m_terr [2];
  int            m_age [2];

  initial begin
    logic r0, r1, win;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_busy[i] = 1'b0; m_due[i] = 1'b0; m_owner[i] = 1'b0; m_wr[i] = 1'b0;
          m_last[i] = 1'b1; m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0;
          m_rv[i] = 1'b0; m_rh[i] = 1'b0; m_terr[i] = 1'b0; m_age[i] = 0;
        end else if (m_due[i]) begin
          m_due[i] = 1'b0;
        end else if (m_busy[i]) begin
          m_age[i]++;
          if (l2_ready[i]) begin
            m_rdata[i] = l2_data_in[i];
            m_rv[i]    = l2_block_valid[i];
            m_rh[i]    = l2_hit[i];
            m_busy[i]  = 1'b0;
            m_due[i]   = 1'b1;
          end else if (m_age[i] >= TO) begin
            m_terr[i] = 1'b1;
            m_rv[i]   = 1'b0;
            m_rh[i]   = 1'b0;
            m_busy[i] = 1'b0;
            m_due[i]  = 1'b1;
          end
        end else begin
          r0 = p0_read || p0_write;
          r1 = p1_read || p1_write;
          if (r0 || r1) begin
            // Instance 1 is fixed priority; instance 0 alternates on a tie.
            if (r0 && r1) win = (i == 1) ? 1'b0 : !m_last[i];
            else          win = r1;
            m_owner[i] = win;
            m_last[i]  = win;
            m_busy[i]  = 1'b1;
            m_age[i]   = 0;
            m_wr[i]    = win ? p1_write : p0_write;
            m_addr[i]  = win ? p1_addr : p0_addr;
            m_wdata[i] = win ? p1_data_in : p0_data_in;
          end
        end
      end
      if (rst) m_live = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard of served ports, in order, per instance
  // ---------------------------------------------------------------------------
  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];

  task automatic push_exp(input logic [1:0] rr_port, input logic [1:0] fp_port);
    exp_q0.push_back(rr_port);
    exp_q1.push_back(fp_port);
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] got, want;
    forever begin
      @(negedge clk);
      if (m_live) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("u%0d p0_ready", i), 64'(p0_ready[i]), 64'(m_due[i] && !m_owner[i]));
          chk($sformatf("u%0d p1_ready", i), 64'(p1_ready[i]), 64'(m_due[i] && m_owner[i]));
          chk($sformatf("u%0d l2_read", i), 64'(l2_read[i]), 64'(m_busy[i] && !m_wr[i] && !l2_ready[i]));
          chk($sformatf("u%0d l2_write", i), 64'(l2_write[i]), 64'(m_busy[i] && m_wr[i] && !l2_ready[i]));
          chk($sformatf("u%0d l2_addr", i), 64'(l2_addr[i]), 64'(m_addr[i]));
          chk_blk($sformatf("u%0d l2_data_out", i), l2_data_out[i], m_wdata[i]);
          chk_blk($sformatf("u%0d rsp_data", i), rsp_data[i], m_rdata[i]);
          chk($sformatf("u%0d rsp_valid", i), 64'(rsp_valid[i]), 64'(m_rv[i]));
          chk($sformatf("u%0d rsp_hit", i), 64'(rsp_hit[i]), 64'(m_rh[i]));
          chk($sformatf("u%0d timeout_err", i), 64'(timeout_err[i]), 64'(m_terr[i]));

          if (p0_ready[i] || p1_ready[i]) begin
            got = p1_ready[i] ? 2'd1 : 2'd0;
            if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
              total++;
              bad++;
              $display("FAIL u%0d served_port: got pulse on port %0d, want no pulse", i, got);
            end else begin
              want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk($sformatf("u%0d served_port", i), 64'(got), 64'(want));
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want end of test");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    p0_addr = '0; p1_addr = '0; p0_data_in = '0; p1_data_in = '0;
    p0_read = 1'b0; p1_read = 1'b0; p0_write = 1'b0; p1_write = 1'b0;

    // Reset state.
    step_n(2);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset state", i), 64'(dbg_state[i]), 64'd0);
      chk($sformatf("u%0d reset l2_addr", i), 64'(l2_addr[i]), 64'd0);
      chk_blk($sformatf("u%0d reset rsp_data", i), rsp_data[i], '0);
      chk($sformatf("u%0d reset timeout_err", i), 64'(timeout_err[i]), 64'd0);
      chk($sformatf("u%0d reset p0_ready", i), 64'(p0_ready[i]), 64'd0);
    end
    step();
    rst = 1'b0;
    step();

    // 1: single read on p0, L2 hit in cycle 3, port ready in cycle 4.
    push_exp(2'd0, 2'd0);
    l2_lat = 3; hit_v = 1'b1; valid_v = 1'b1; l2_pat = 32'hDEAD_BEEF;
    p0_addr = 11'h040; p0_data_in = make_blk(32'h0A0A_0000); p0_read = 1'b1;
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d s1 c1 l2_read", i), 64'(l2_read[i]), 64'd1);
      chk($sformatf("u%0d s1 c1 l2_addr", i), 64'(l2_addr[i]), 64'h040);
    end
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d s1 c2 l2_read", i), 64'(l2_read[i]), 64'd1);
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d s1 c3 l2_read", i), 64'(l2_read[i]), 64'd0);
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d s1 c4 p0_ready", i), 64'(p0_ready[i]), 64'd1);
      chk($sformatf("u%0d s1 c4 p1_ready", i), 64'(p1_ready[i]), 64'd0);
      chk($sformatf("u%0d s1 c4 rsp_hit", i), 64'(rsp_hit[i]), 64'd1);
      chk($sformatf("u%0d s1 c4 rsp_valid", i), 64'(rsp_valid[i]), 64'd1);
      chk($sformatf("u%0d s1 c4 word0", i), 64'(rsp_data[i][31:0]), 64'hDEAD_BEEF);
    end
    step();
    p0_read = 1'b0;
    step_n(2);

    // 2/3: p0 read and p1 write held together from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    push_exp(2'd0, 2'd0);
    push_exp(2'd1, 2'd0);
    push_exp(2'd0, 2'd0);
    push_exp(2'd1, 2'd0);
    push_exp(2'd1, 2'd1);
    l2_lat = 3; hit_v = 1'b0; valid_v = 1'b1;
    p0_addr = 11'h080; p0_data_in = make_blk(32'h0000_1000); p0_read = 1'b1;
    p1_addr = 11'h0C4; p1_data_in = make_blk(32'h0000_2000); p1_write = 1'b1;
    step_n(6);
    @(negedge clk);
    chk("u0 s2 second grant l2_write", 64'(l2_write[0]), 64'd1);
    chk("u0 s2 second grant l2_addr", 64'(l2_addr[0]), 64'h0C4);
    chk("u1 s3 second grant l2_read", 64'(l2_read[1]), 64'd1);
    chk("u1 s3 second grant l2_addr", 64'(l2_addr[1]), 64'h080);
    step_n(14);
    p0_read = 1'b0;
    step_n(5);
    p1_write = 1'b0;
    step_n(2);

    // 4: granted p1 changes its address during BUSY.
    push_exp(2'd1, 2'd1);
    l2_lat = 5; hit_v = 1'b1; valid_v = 1'b1;
    p1_addr = 11'h100; p1_read = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) begin
        p1_addr    = 11'h7E0;
        p1_data_in = make_blk(32'h0000_3000);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk($sformatf("u%0d s4 c%0d l2_addr", i, k), 64'(l2_addr[i]), 64'h100);
    end
    step_n(2);
    p1_read = 1'b0;
    step_n(2);

    // 5: L2 never answers; 8 BUSY cycles then a ready pulse with the error set.
    push_exp(2'd0, 2'd0);
    l2_hang = 1'b1;
    p0_addr = 11'h3FF; p0_data_in = make_blk(32'h0000_4000); p0_write = 1'b1;
    step_n(8);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d s5 c8 timeout_err", i), 64'(timeout_err[i]), 64'd0);
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d s5 c9 p0_ready", i), 64'(p0_ready[i]), 64'd1);
      chk($sformatf("u%0d s5 c9 timeout_err", i), 64'(timeout_err[i]), 64'd1);
      chk($sformatf("u%0d s5 c9 rsp_valid", i), 64'(rsp_valid[i]), 64'd0);
      chk($sformatf("u%0d s5 c9 rsp_hit", i), 64'(rsp_hit[i]), 64'd0);
    end
    step();
    p0_write = 1'b0; l2_hang = 1'b0; l2_lat = 2;
    push_exp(2'd1, 2'd1);
    p1_addr = 11'h155; p1_read = 1'b1;
    step_n(3);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d s5 next p1_ready", i), 64'(p1_ready[i]), 64'd1);
      chk($sformatf("u%0d s5 next timeout_err", i), 64'(timeout_err[i]), 64'd1);
      chk($sformatf("u%0d s5 next rsp_valid", i), 64'(rsp_valid[i]), 64'd1);
    end
    step();
    p1_read = 1'b0;
    step_n(2);

    // 6: reset in the middle of BUSY, then a fresh p1 request.
    push_exp(2'd1, 2'd1);
    l2_lat = 5;
    p0_addr = 11'h2A0; p0_read = 1'b1;
    step_n(3);
    rst = 1'b1;
    step();
    rst = 1'b0; p0_read = 1'b0;
    p1_addr = 11'h200; p1_read = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d s6 state", i), 64'(dbg_state[i]), 64'd0);
      chk($sformatf("u%0d s6 l2_read", i), 64'(l2_read[i]), 64'd0);
      chk($sformatf("u%0d s6 l2_addr", i), 64'(l2_addr[i]), 64'd0);
      chk_blk($sformatf("u%0d s6 l2_data_out", i), l2_data_out[i], '0);
      chk_blk($sformatf("u%0d s6 rsp_data", i), rsp_data[i], '0);
      chk($sformatf("u%0d s6 rsp_valid", i), 64'(rsp_valid[i]), 64'd0);
      chk($sformatf("u%0d s6 timeout_err", i), 64'(timeout_err[i]), 64'd0);
      chk($sformatf("u%0d s6 p0_ready", i), 64'(p0_ready[i]), 64'd0);
    end
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d s6 regrant l2_read", i), 64'(l2_read[i]), 64'd1);
      chk($sformatf("u%0d s6 regrant l2_addr", i), 64'(l2_addr[i]), 64'h200);
    end
    step_n(5);
    step();
    p1_read = 1'b0;
    step_n(3);

    // Every expected ready pulse must have been seen.
    chk("u0 pulses outstanding", 64'(exp_q0.size()), 64'd0);
    chk("u1 pulses outstanding", 64'(exp_q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Two-requester front end for the shared L2 cache.
- Port 0 is the L1 instruction side and port 1 is the L1 data side. Both issue block read/write requests.
- The arbiter grants one request at a time and latches its address and data. It holds the L2 read/write strobes stable for the whole L2 transaction and routes the L2 response back to the granted port only.
- It sits between the two L1 controllers and the L2 cache's L1-facing interface.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 11, address width, identical to the L2 address width.
- BLOCK_SIZE, 32, words per block. Block buses are BLOCK_SIZE x DATA_WIDTH packed.
- FIXED_PRIORITY, 0. 0 = round-robin; 1 = port 0 always wins.
- TIMEOUT_CYCLES, 255. Maximum number of BUSY cycles before the transaction is abandoned. Must be at least 4.

Ports:
- Interface rule (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- p0_addr, p1_addr  in  ADDR_WIDTH  request block address.
- p0_data_in, p1_data_in  in  BLOCK_SIZE x DATA_WIDTH  write block.
- p0_read, p1_read  in  1  read request; held high until that port's ready.
- p0_write, p1_write  in  1  write request; held high until that port's ready.
- p0_ready, p1_ready  out  1  one-cycle completion pulse.
- rsp_data  out  BLOCK_SIZE x DATA_WIDTH  returned block; meaningful only while p0_ready or p1_ready is high.
- rsp_valid  out  1  returned block is valid.
- rsp_hit  out  1  the L2 reported a hit.
- l2_addr  out  ADDR_WIDTH  latched address.
- l2_data_out  out  BLOCK_SIZE x DATA_WIDTH  latched write block.
- l2_read, l2_write  out  1  L2 strobes.
- l2_data_in  in  BLOCK_SIZE x DATA_WIDTH  L2 block output.
- l2_block_valid, l2_hit, l2_ready  in  1  L2 response signals; l2_ready is a one-cycle pulse.
- timeout_err  out  1  sticky error flag.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset state:
  - state = IDLE.
  - All outputs 0, including l2_addr, l2_data_out and rsp_data.
  - last_grant = 1, so port 0 wins the first contention.
  - Timeout counter = 0; timeout_err = 0.
  - A reset mid-transaction abandons the transaction silently; no ready pulse is issued.
- A port is requesting when its read or write is high. If both are high on one port, the request is treated as a write.
- IDLE:
  - If any port is requesting, grant one of them.
    - Round-robin mode: the non-last_grant port wins on contention.
    - FIXED_PRIORITY = 1: port 0 wins on contention.
  - On the grant, register:
    - the granted port id;
    - l2_addr and l2_data_out from that port;
    - the operation (read or write);
    - last_grant = the granted port.
  - Go to BUSY.
  - Requests dropped before a grant are ignored; no ready pulse is issued for them.
- BUSY:
  - l2_read and l2_write = (latched op) AND NOT l2_ready. This gating is combinational, so the L2 never samples a stale strobe on the cycle it signals completion.
  - Port inputs are ignored. Changes to the granted port's addr/data after the grant have no effect.
  - Timeout counter increments every BUSY cycle.
  - On l2_ready = 1:
    - Capture rsp_data <= l2_data_in, rsp_valid <= l2_block_valid, rsp_hit <= l2_hit.
    - Go to DONE.
  - Else if the counter reaches TIMEOUT_CYCLES:
    - Set timeout_err = 1; rsp_valid = 0; rsp_hit = 0.
    - Go to DONE.
  - If l2_ready and the timeout coincide, l2_ready wins.
- DONE:
  - Pulse the granted port's ready for exactly one cycle; the other port's ready stays 0.
  - Clear the timeout counter and the L2 strobes.
  - Go to IDLE.
  - rsp_data, rsp_valid and rsp_hit hold until the next capture.
- Throughput:
  - At most one transaction is outstanding.
  - A requester may re-request in the cycle after its ready pulse.
  - The minimum gap between consecutive grants is 1 IDLE cycle.
- Latency:
  - Request visible in cycle 0 (IDLE) -> l2_read high in cycle 1.
  - An L2 hit (ready in cycle 3) -> port ready in cycle 4.
  - In general: port ready = 1 cycle after l2_ready.
- timeout_err is cleared only by rst.

Test Plan:
1. Single read on p0, addr 0x040; L2 returns a hit with a block whose word0 = 0xDEADBEEF and l2_ready in cycle 3 -> l2_read high in cycles 1-2 and low in cycle 3; p0_ready pulses in cycle 4 with rsp_hit = 1, rsp_valid = 1 and rsp_data word0 = 0xDEADBEEF; p1_ready stays 0.
2. p0 read and p1 write asserted in the same cycle, both held, round-robin mode -> p0 is granted first; p1 is granted in the IDLE cycle after p0_ready, with l2_write = 1 and l2_addr = p1_addr. Repeat with both held -> the grant alternates p0, p1, p0, p1.
3. Same as scenario 2 with FIXED_PRIORITY = 1 and p0 re-requesting immediately -> p0 is granted in every arbitration; p1 waits until p0 drops.
4. Granted p1 changes p1_addr from 0x100 to 0x7E0 during BUSY -> l2_addr stays 0x100 for the whole transaction.
5. L2 never asserts l2_ready, TIMEOUT_CYCLES = 8 -> after 8 BUSY cycles timeout_err = 1, the granted port's ready pulses with rsp_valid = 0, and the next request is served normally with timeout_err still 1.
6. rst asserted in the middle of BUSY -> the next cycle has state IDLE, all outputs 0 and no ready pulse; a fresh p1 request is then granted within 1 cycle.
